// File: rtl/bank_rd_sched.sv
// Three-requester (i, d, c) banked read scheduler with one holding slot per requester,
// same-bank conflict resolution and starvation promotion for d and c; read data valid one cycle after grant.
module bank_rd_sched #(
   parameter int BANKBITS = 5,
   parameter int WORDBITS = 10,
   parameter int STARVE   = 3,
   localparam int A       = BANKBITS + WORDBITS
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_req,
   input  logic [A-1:0] i_addr,
   output logic         i_rdy,
   output logic         i_gnt,
   output logic         i_vld,
   input  logic         d_req,
   input  logic [A-1:0] d_addr,
   output logic         d_rdy,
   output logic         d_gnt,
   output logic         d_vld,
   input  logic         c_req,
   input  logic [A-1:0] c_addr,
   output logic         c_rdy,
   output logic         c_gnt,
   output logic         c_vld,
   output logic         mi_en,
   output logic [A-1:0] mi_addr,
   output logic         md_en,
   output logic [A-1:0] md_addr,
   output logic         mc_en,
   output logic [A-1:0] mc_addr,
   output logic         o_en
);

   // Index 0 = i, 1 = d, 2 = c throughout.
   logic [2:0]          req, pend, gnt, gnt_raw, rdy, acc, vld_q;
   logic [A-1:0]        in_addr [3];
   logic [A-1:0]        addr_q  [3];
   logic [A-1:0]        last_q  [3];
   logic [BANKBITS-1:0] bank    [3];
   logic [3:0]          starve_d, starve_c;
   logic                prom_d, prom_c;
   logic [2:0][1:0]     ord;
   logic                hit;

   assign req        = {c_req, d_req, i_req};
   assign in_addr[0] = i_addr;
   assign in_addr[1] = d_addr;
   assign in_addr[2] = c_addr;

   assign prom_d = pend[1] && (starve_d == 4'(STARVE));
   assign prom_c = pend[2] && (starve_c == 4'(STARVE));

   // Greedy issue in rank order: a slot only loses to a higher-ranked slot that actually issued.
   always_comb begin
      gnt_raw = '0;
      hit     = 1'b0;
      for (int k = 0; k < 3; k++) bank[k] = addr_q[k][WORDBITS +: BANKBITS];
      case ({prom_d, prom_c})
         2'b11:   ord = {2'd0, 2'd2, 2'd1};
         2'b10:   ord = {2'd2, 2'd0, 2'd1};
         2'b01:   ord = {2'd1, 2'd0, 2'd2};
         default: ord = {2'd2, 2'd1, 2'd0};
      endcase
      for (int p = 0; p < 3; p++) begin
         hit = 1'b0;
         for (int j = 0; j < 3; j++)
            if (gnt_raw[j] && (bank[j] == bank[ord[p]])) hit = 1'b1;
         if (pend[ord[p]] && !hit) gnt_raw[ord[p]] = 1'b1;
      end
   end

   assign gnt = rst ? 3'b000 : gnt_raw;
   assign rdy = {3{rst}} | ~pend | gnt;
   assign acc = req & rdy & {3{~rst}};

   always_ff @(posedge clk) begin
      if (rst) begin
         pend     <= '0;
         vld_q    <= '0;
         starve_d <= '0;
         starve_c <= '0;
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (acc[k]) begin
               pend[k]   <= 1'b1;
               addr_q[k] <= in_addr[k];
            end else if (gnt[k]) begin
               pend[k]   <= 1'b0;
            end
            if (gnt[k]) last_q[k] <= addr_q[k];
         end
         vld_q <= gnt;
         // An issue always restarts the count, including when the slot reloads in the same cycle.
         if (gnt[1])                                  starve_d <= '0;
         else if (pend[1] && starve_d != 4'(STARVE))  starve_d <= starve_d + 4'd1;
         if (gnt[2])                                  starve_c <= '0;
         else if (pend[2] && starve_c != 4'(STARVE))  starve_c <= starve_c + 4'd1;
      end
   end

   assign i_gnt   = gnt[0];
   assign d_gnt   = gnt[1];
   assign c_gnt   = gnt[2];
   assign i_rdy   = rdy[0];
   assign d_rdy   = rdy[1];
   assign c_rdy   = rdy[2];
   assign i_vld   = vld_q[0];
   assign d_vld   = vld_q[1];
   assign c_vld   = vld_q[2];
   assign mi_en   = gnt[0];
   assign md_en   = gnt[1];
   assign mc_en   = gnt[2];
   // The array port address holds its last issued value between reads.
   assign mi_addr = gnt[0] ? addr_q[0] : last_q[0];
   assign md_addr = gnt[1] ? addr_q[1] : last_q[1];
   assign mc_addr = gnt[2] ? addr_q[2] : last_q[2];
   assign o_en    = |gnt;

endmodule

// File: tb/tb_bank_rd_sched.sv
// Directed bench for bank_rd_sched: per-scenario tasks with hand-computed grant/valid tables.
module tb_bank_rd_sched;

   localparam int A = 15;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_req, d_req, c_req;
   logic [A-1:0] i_addr, d_addr, c_addr;
   logic         i_rdy, d_rdy, c_rdy;
   logic         i_gnt, d_gnt, c_gnt;
   logic         i_vld, d_vld, c_vld;
   logic         mi_en, md_en, mc_en, o_en;
   logic [A-1:0] mi_addr, md_addr, mc_addr;

   int checks   = 0;
   int failures = 0;

   bank_rd_sched dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdy(i_rdy), .i_gnt(i_gnt), .i_vld(i_vld),
      .d_req(d_req), .d_addr(d_addr), .d_rdy(d_rdy), .d_gnt(d_gnt), .d_vld(d_vld),
      .c_req(c_req), .c_addr(c_addr), .c_rdy(c_rdy), .c_gnt(c_gnt), .c_vld(c_vld),
      .mi_en(mi_en), .mi_addr(mi_addr), .md_en(md_en), .md_addr(md_addr),
      .mc_en(mc_en), .mc_addr(mc_addr), .o_en(o_en)
   );

   always #5 clk = ~clk;

   function automatic logic [A-1:0] mk(input int bank, input int word);
      logic [4:0] b;
      logic [9:0] w;
      b = 5'(bank);
      w = 10'(word);
      return {b, w};
   endfunction

   // Drive one cycle's inputs at the falling edge; m = {i,d,c} request mask.
   task automatic drive(input logic [2:0] m, input int bi, input int bd, input int bc,
                        input int w, input logic r);
      @(negedge clk);
      rst    = r;
      i_req  = m[2];
      d_req  = m[1];
      c_req  = m[0];
      i_addr = mk(bi, w);
      d_addr = mk(bd, w);
      c_addr = mk(bc, w);
      #1;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         drive(3'b000, 0, 0, 0, 0, (k < 2));
         if ({i_rdy, d_rdy, c_rdy} !== 3'b111) begin
            failures++; $display("FAIL reset_rdy c%0d: got %b want 111", k, {i_rdy, d_rdy, c_rdy});
         end
         checks++;
         if ({i_gnt, d_gnt, c_gnt, o_en} !== 4'b0000) begin
            failures++; $display("FAIL reset_gnt c%0d: got %b want 0000", k, {i_gnt, d_gnt, c_gnt, o_en});
         end
         checks++;
         if (k > 0) begin
            if ({i_vld, d_vld, c_vld} !== 3'b000) begin
               failures++; $display("FAIL reset_vld c%0d: got %b want 000", k, {i_vld, d_vld, c_vld});
            end
            checks++;
         end
      end
   endtask

   task automatic test_parallel_issue();
      drive(3'b111, 1, 2, 3, 0, 1'b0);
      drive(3'b000, 1, 2, 3, 0, 1'b0);
      if ({i_gnt, d_gnt, c_gnt, o_en} !== 4'b1111) begin
         failures++; $display("FAIL par_gnt: got %b want 1111", {i_gnt, d_gnt, c_gnt, o_en});
      end
      checks++;
      if ({mi_en, md_en, mc_en} !== 3'b111 || mi_addr !== mk(1, 0) || md_addr !== mk(2, 0)
          || mc_addr !== mk(3, 0)) begin
         failures++; $display("FAIL par_addr: got %h %h %h want %h %h %h", mi_addr, md_addr, mc_addr,
                              mk(1, 0), mk(2, 0), mk(3, 0));
      end
      checks++;
      drive(3'b000, 1, 2, 3, 0, 1'b0);
      if ({i_vld, d_vld, c_vld, i_gnt, d_gnt, c_gnt} !== 6'b111000) begin
         failures++; $display("FAIL par_vld: got %b want 111000", {i_vld, d_vld, c_vld, i_gnt, d_gnt, c_gnt});
      end
      checks++;
      drive(3'b000, 1, 2, 3, 0, 1'b0);
      if ({i_vld, d_vld, c_vld, o_en} !== 4'b0000) begin
         failures++; $display("FAIL par_idle: got %b want 0000", {i_vld, d_vld, c_vld, o_en});
      end
      checks++;
   endtask

   task automatic test_conflict_skip();
      logic [2:0] rq [4] = '{3'b111, 3'b000, 3'b000, 3'b000};
      logic [2:0] eg [4] = '{3'b000, 3'b101, 3'b010, 3'b000};
      for (int k = 0; k < 4; k++) begin
         drive(rq[k], 4, 4, 9, k, 1'b0);
         if ({i_gnt, d_gnt, c_gnt} !== eg[k]) begin
            failures++; $display("FAIL skip_gnt c%0d: got %b want %b", k, {i_gnt, d_gnt, c_gnt}, eg[k]);
         end
         checks++;
         if (k > 0 && {i_vld, d_vld, c_vld} !== eg[k-1]) begin
            failures++; $display("FAIL skip_vld c%0d: got %b want %b", k, {i_vld, d_vld, c_vld}, eg[k-1]);
         end
         if (k > 0) checks++;
      end
   endtask

   task automatic test_i_vs_d();
      logic [2:0] rq [8] = '{3'b110, 3'b110, 3'b110, 3'b110, 3'b110, 3'b000, 3'b000, 3'b000};
      logic [2:0] eg [8] = '{3'b000, 3'b100, 3'b100, 3'b100, 3'b010, 3'b100, 3'b010, 3'b000};
      for (int k = 0; k < 8; k++) begin
         drive(rq[k], 5, 5, 0, k, 1'b0);
         if ({i_gnt, d_gnt, c_gnt} !== eg[k]) begin
            failures++; $display("FAIL ivd_gnt c%0d: got %b want %b", k, {i_gnt, d_gnt, c_gnt}, eg[k]);
         end
         checks++;
         if (k >= 1 && k <= 3 && d_rdy !== 1'b0) begin
            failures++; $display("FAIL ivd_drdy c%0d: got %b want 0", k, d_rdy);
         end
         if (k >= 1 && k <= 3) checks++;
      end
   endtask

   task automatic test_starvation();
      logic [2:0] eg [14] = '{3'b000, 3'b100, 3'b100, 3'b100, 3'b010, 3'b001, 3'b100,
                              3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001, 3'b000};
      for (int k = 0; k < 14; k++) begin
         drive((k < 10) ? 3'b111 : 3'b000, 7, 7, 7, k, 1'b0);
         if ({i_gnt, d_gnt, c_gnt} !== eg[k]) begin
            failures++; $display("FAIL starve_gnt c%0d: got %b want %b", k, {i_gnt, d_gnt, c_gnt}, eg[k]);
         end
         checks++;
         if (k > 0 && {i_vld, d_vld, c_vld} !== eg[k-1]) begin
            failures++; $display("FAIL starve_vld c%0d: got %b want %b", k, {i_vld, d_vld, c_vld}, eg[k-1]);
         end
         if (k > 0) checks++;
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         rst    = 1'b0;
         i_req  = 1'b0;
         c_req  = 1'b0;
         d_req  = (k < 6);
         d_addr = mk(2, 100 + k);
         #1;
         if (k < 6) begin
            if (d_rdy !== 1'b1) begin
               failures++; $display("FAIL b2b_rdy c%0d: got %b want 1", k, d_rdy);
            end
            checks++;
         end
         if (d_gnt !== ((k >= 1) && (k <= 6))) begin
            failures++; $display("FAIL b2b_gnt c%0d: got %b want %b", k, d_gnt, (k >= 1) && (k <= 6));
         end
         checks++;
         if (k >= 1 && md_addr !== mk(2, 100 + ((k <= 6) ? k - 1 : 5))) begin
            failures++; $display("FAIL b2b_addr c%0d: got %h want %h", k, md_addr,
                                 mk(2, 100 + ((k <= 6) ? k - 1 : 5)));
         end
         if (k >= 1) checks++;
         if (d_vld !== ((k >= 2) && (k <= 7))) begin
            failures++; $display("FAIL b2b_vld c%0d: got %b want %b", k, d_vld, (k >= 2) && (k <= 7));
         end
         checks++;
      end
   endtask

   task automatic test_reset_mid();
      logic [2:0] rq [11] = '{3'b101, 3'b100, 3'b000, 3'b000, 3'b101, 3'b101, 3'b101,
                              3'b101, 3'b000, 3'b000, 3'b000};
      logic [2:0] eg [11] = '{3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 3'b100, 3'b100,
                              3'b100, 3'b001, 3'b100, 3'b000};
      for (int k = 0; k < 11; k++) begin
         drive(rq[k], 7, 0, 7, k, (k == 2));
         if ({i_gnt, d_gnt, c_gnt} !== eg[k]) begin
            failures++; $display("FAIL rmid_gnt c%0d: got %b want %b", k, {i_gnt, d_gnt, c_gnt}, eg[k]);
         end
         checks++;
         if (k > 0 && {i_vld, d_vld, c_vld} !== eg[k-1]) begin
            failures++; $display("FAIL rmid_vld c%0d: got %b want %b", k, {i_vld, d_vld, c_vld}, eg[k-1]);
         end
         if (k > 0) checks++;
         if ((k == 2 || k == 3) && (c_rdy !== 1'b1 || o_en !== 1'b0)) begin
            failures++; $display("FAIL rmid_rdy c%0d: got rdy=%b o_en=%b want rdy=1 o_en=0", k, c_rdy, o_en);
         end
         if (k == 2 || k == 3) checks++;
      end
   endtask

   initial begin
      rst = 1'b1;
      i_req = 1'b0; d_req = 1'b0; c_req = 1'b0;
      i_addr = '0; d_addr = '0; c_addr = '0;
      test_reset();
      test_parallel_issue();
      test_conflict_skip();
      test_i_vs_d();
      test_starvation();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
